// File: rtl/stream_ingress_buffer_pkg.sv
// Shared types for the stream ingress buffer: beat payload, FSM states and terminator beat.
package stream_pkg;

    localparam int unsigned DATA_WD      = 32;
    localparam int unsigned DATA_BYTE_WD = DATA_WD / 8;

    typedef struct packed {
        logic [DATA_WD-1:0]      data;
        logic [DATA_BYTE_WD-1:0] keep;
        logic                    last;
    } beat_t;

    typedef enum logic [1:0] {
        PASS,
        DROP,
        TERM
    } ingress_state_t;

    // Closes a frame that lost its tail: no bytes, last set.
    localparam beat_t TERM_BEAT = '{data: '0, keep: '0, last: 1'b1};

endpackage

// File: rtl/stream_ingress_buffer_if.sv
// Beat stream in (no backpressure), handshaked stream out, and frame length report.
interface stream_ingress_buffer_if #(
    parameter int unsigned DATA_WD      = stream_pkg::DATA_WD,
    parameter int unsigned DATA_BYTE_WD = stream_pkg::DATA_BYTE_WD,
    parameter int unsigned LEN_WD       = 16
);
    logic                    valid_in;
    logic                    last_in;
    logic [DATA_BYTE_WD-1:0] keep_in;
    logic [DATA_WD-1:0]      data_in;

    logic                    valid_out;
    logic                    ready_out;
    logic                    last_out;
    logic [DATA_BYTE_WD-1:0] keep_out;
    logic [DATA_WD-1:0]      data_out;

    logic                    len_valid;
    logic [LEN_WD-1:0]       len_bytes;
    logic                    len_err;
    logic                    overflow;

    modport slave (
        input  valid_in, last_in, keep_in, data_in, ready_out,
        output valid_out, last_out, keep_out, data_out,
        output len_valid, len_bytes, len_err, overflow
    );

    modport master (
        output valid_in, last_in, keep_in, data_in, ready_out,
        input  valid_out, last_out, keep_out, data_out,
        input  len_valid, len_bytes, len_err, overflow
    );
endinterface

// File: rtl/stream_ingress_buffer_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy level; full/empty from level.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             full;
    logic             do_wr;
    logic             do_rd;

    assign full      = (level_q == LW'(DEPTH));
    assign empty_o   = (level_q == '0);
    assign do_wr     = wr_en_i && !full;
    assign do_rd     = rd_en_i && !empty_o;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign level_o   = level_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_q + LW'(do_wr) - LW'(do_rd);
        end
    end

    // Storage needs no reset; the level gates what is visible.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/stream_ingress_buffer.sv
// Ingress buffer: absorbs an unthrottled beat stream, counts bytes per frame and
// closes frames with a terminator beat when overflow forces beats to be dropped.
module stream_ingress_buffer
    import stream_pkg::*;
#(
    parameter int unsigned DATA_WD      = stream_pkg::DATA_WD,
    parameter int unsigned DATA_BYTE_WD = stream_pkg::DATA_BYTE_WD,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned LEN_WD       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    stream_ingress_buffer_if.slave bus
);
    localparam int unsigned BEAT_WD = DATA_WD + DATA_BYTE_WD + 1;
    localparam int unsigned LVL_WD  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned PC_WD   = $clog2(DATA_BYTE_WD) + 1;
    localparam int unsigned SUM_WD  = LEN_WD + 1;

    ingress_state_t    state_q, state_d;
    logic [LEN_WD-1:0] cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              ovf_q, ovf_d;
    logic              pend_q, pend_d;
    logic              pend_last_q, pend_last_d;
    logic              len_valid_q, len_valid_d;
    logic [LEN_WD-1:0] len_bytes_q, len_bytes_d;
    logic              len_err_q, len_err_d;

    logic               wr_en;
    beat_t              wr_beat;
    beat_t              in_beat;
    beat_t              head;
    logic [BEAT_WD-1:0] rd_data;
    logic [LVL_WD-1:0]  level;
    logic               empty;
    logic               full;
    logic [PC_WD-1:0]   keep_cnt;
    logic [SUM_WD-1:0]  cnt_sum_w;
    logic [LEN_WD-1:0]  cnt_sum;
    logic               term_any;
    logic               term_last;

    sync_fifo #(
        .WIDTH (BEAT_WD),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_en),
        .wr_data_i (BEAT_WD'(wr_beat)),
        .rd_en_i   (bus.ready_out),
        .rd_data_o (rd_data),
        .empty_o   (empty),
        .level_o   (level)
    );

    assign full    = (level == LVL_WD'(FIFO_DEPTH));
    assign in_beat = '{data: bus.data_in, keep: bus.keep_in, last: bus.last_in};

    always_comb begin
        keep_cnt = '0;
        for (int unsigned i = 0; i < DATA_BYTE_WD; i++) begin
            keep_cnt = keep_cnt + PC_WD'(bus.keep_in[i]);
        end
    end

    // Saturating byte count including the current beat.
    assign cnt_sum_w = {1'b0, cnt_q} + SUM_WD'(keep_cnt);
    assign cnt_sum   = cnt_sum_w[LEN_WD] ? '1 : cnt_sum_w[LEN_WD-1:0];

    // Most recent beat dropped while a terminator is owed decides where the next frame starts.
    assign term_any  = bus.valid_in | pend_q;
    assign term_last = bus.valid_in ? bus.last_in : pend_last_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        ovf_d       = ovf_q;
        pend_d      = pend_q;
        pend_last_d = pend_last_q;
        len_valid_d = 1'b0;
        len_bytes_d = len_bytes_q;
        len_err_d   = len_err_q;
        wr_en       = 1'b0;
        wr_beat     = TERM_BEAT;

        unique case (state_q)
            PASS: begin
                if (bus.valid_in && !full) begin
                    wr_en   = 1'b1;
                    wr_beat = in_beat;
                    cnt_d   = cnt_sum;
                    if (bus.last_in) begin
                        len_valid_d = 1'b1;
                        len_bytes_d = cnt_sum;
                        len_err_d   = err_q;
                        cnt_d       = '0;
                        err_d       = 1'b0;
                    end
                end else if (bus.valid_in) begin
                    ovf_d       = 1'b1;
                    err_d       = 1'b1;
                    pend_d      = 1'b0;
                    pend_last_d = 1'b0;
                    state_d     = bus.last_in ? TERM : DROP;
                end
            end
            DROP: begin
                if (bus.valid_in) begin
                    ovf_d = 1'b1;
                    if (bus.last_in && !full) begin
                        wr_en       = 1'b1;
                        len_valid_d = 1'b1;
                        len_bytes_d = cnt_q;
                        len_err_d   = err_q;
                        cnt_d       = '0;
                        err_d       = 1'b0;
                        state_d     = PASS;
                    end else if (bus.last_in) begin
                        pend_d      = 1'b0;
                        pend_last_d = 1'b0;
                        state_d     = TERM;
                    end
                end
            end
            TERM: begin
                if (bus.valid_in) begin
                    ovf_d       = 1'b1;
                    pend_d      = 1'b1;
                    pend_last_d = bus.last_in;
                end
                if (!full) begin
                    wr_en       = 1'b1;
                    len_valid_d = 1'b1;
                    len_bytes_d = cnt_q;
                    len_err_d   = err_q;
                    cnt_d       = '0;
                    err_d       = term_any;
                    pend_d      = 1'b0;
                    pend_last_d = 1'b0;
                    if (!term_any)     state_d = PASS;
                    else if (term_last) state_d = TERM;
                    else               state_d = DROP;
                end
            end
            default: state_d = PASS;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= PASS;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            len_valid_q <= 1'b0;
            len_bytes_q <= '0;
            len_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            ovf_q       <= ovf_d;
            pend_q      <= pend_d;
            pend_last_q <= pend_last_d;
            len_valid_q <= len_valid_d;
            len_bytes_q <= len_bytes_d;
            len_err_q   <= len_err_d;
        end
    end

    assign head          = beat_t'(rd_data);
    assign bus.valid_out = !empty;
    assign bus.last_out  = !empty && head.last;
    assign bus.keep_out  = empty ? '0 : head.keep;
    assign bus.data_out  = empty ? '0 : head.data;
    assign bus.len_valid = len_valid_q;
    assign bus.len_bytes = len_bytes_q;
    assign bus.len_err   = len_err_q;
    assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_stream_ingress_buffer.sv
// Bench for stream_ingress_buffer: directed frames plus random traffic against a
// queue-based reference model; a second instance with LEN_WD=4 checks saturation.
module tb_stream_ingress_buffer;
    import stream_pkg::*;

    localparam int MODEL_DEPTH = 16;
    localparam int LEN_MAX     = 65535;
    localparam int MODE_NORMAL  = 0;
    localparam int MODE_DISCARD = 1;
    localparam int MODE_OWE     = 2;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } mbeat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stream_ingress_buffer_if bus ();
    stream_ingress_buffer_if #(.LEN_WD(4)) bus4 ();

    stream_ingress_buffer dut (.clk(clk), .rst(rst), .bus(bus));
    stream_ingress_buffer #(.LEN_WD(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    int n_checks = 0;
    int n_fail   = 0;

    mbeat_t      mq[$];
    mbeat_t      obs_q[$];
    logic [16:0] rep_q[$];

    int m_mode;
    int m_cnt;
    bit m_err, m_ovf, m_pend, m_pend_last;
    bit m_len_valid, m_len_err;
    int m_len_bytes;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_mode = MODE_NORMAL;
        m_cnt = 0;
        m_err = 0; m_ovf = 0; m_pend = 0; m_pend_last = 0;
        m_len_valid = 0; m_len_err = 0; m_len_bytes = 0;
    endtask

    task automatic report_frame();
        m_len_valid = 1;
        m_len_bytes = m_cnt;
        m_len_err   = m_err;
        m_cnt = 0;
        m_err = 0;
    endtask

    // One clock of the frame rules, applied to the occupancy seen at cycle start.
    task automatic model_step(input bit v, input bit l, input logic [3:0] k,
                              input logic [31:0] d, input bit r);
        bit full = (mq.size() == MODEL_DEPTH);
        mbeat_t term = '{data: 32'h0, keep: 4'h0, last: 1'b1};
        m_len_valid = 0;
        if (r && mq.size() > 0) void'(mq.pop_front());
        case (m_mode)
            MODE_NORMAL: if (v) begin
                if (!full) begin
                    mq.push_back('{data: d, keep: k, last: l});
                    m_cnt = m_cnt + $countones(k);
                    if (m_cnt > LEN_MAX) m_cnt = LEN_MAX;
                    if (l) report_frame();
                end else begin
                    m_ovf = 1; m_err = 1; m_pend = 0;
                    m_mode = l ? MODE_OWE : MODE_DISCARD;
                end
            end
            MODE_DISCARD: if (v) begin
                m_ovf = 1;
                if (l && !full) begin
                    mq.push_back(term);
                    report_frame();
                    m_mode = MODE_NORMAL;
                end else if (l) begin
                    m_pend = 0;
                    m_mode = MODE_OWE;
                end
            end
            default: begin
                if (v) begin m_ovf = 1; m_pend = 1; m_pend_last = l; end
                if (!full) begin
                    mq.push_back(term);
                    report_frame();
                    m_err = m_pend;
                    if (!m_pend) m_mode = MODE_NORMAL;
                    else m_mode = m_pend_last ? MODE_OWE : MODE_DISCARD;
                    m_pend = 0;
                end
            end
        endcase
    endtask

    task automatic check_outputs();
        logic [63:0] exp_out;
        exp_out = '0;
        if (mq.size() > 0) exp_out = 64'({1'b1, mq[0].last, mq[0].keep, mq[0].data});
        chk("out_beat", 64'({bus.valid_out, bus.last_out, bus.keep_out, bus.data_out}), exp_out);
        chk("len_valid", 64'(bus.len_valid), 64'(m_len_valid));
        if (m_len_valid)
            chk("len_report", 64'({bus.len_err, bus.len_bytes}), 64'({m_len_err, 16'(m_len_bytes)}));
        chk("overflow", 64'(bus.overflow), 64'(m_ovf));
        if (bus.len_valid) rep_q.push_back({bus.len_err, bus.len_bytes});
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input bit v, input bit l, input logic [3:0] k,
                        input logic [31:0] d, input bit r);
        check_outputs();
        if (bus.valid_out && r) obs_q.push_back({bus.data_out, bus.keep_out, bus.last_out});
        bus.valid_in  = v;
        bus.last_in   = l;
        bus.keep_in   = k;
        bus.data_in   = d;
        bus.ready_out = r;
        model_step(v, l, k, d, r);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_obs();
        obs_q.delete();
        rep_q.delete();
    endtask

    logic [3:0] keeps [4];
    int pv, pr;
    bit seen;

    initial begin
        keeps[0] = 4'hF; keeps[1] = 4'hE; keeps[2] = 4'hC; keeps[3] = 4'h8;
        rst = 1'b1;
        bus.valid_in = 0; bus.last_in = 0; bus.keep_in = '0; bus.data_in = '0; bus.ready_out = 0;
        bus4.valid_in = 0; bus4.last_in = 0; bus4.keep_in = '0; bus4.data_in = '0; bus4.ready_out = 1;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_out", 64'({bus.valid_out, bus.last_out, bus.keep_out, bus.data_out}), 64'h0);
        chk("reset_len", 64'({bus.len_valid, bus.len_err, bus.len_bytes}), 64'h0);
        chk("reset_ovf", 64'(bus.overflow), 64'h0);
        rst = 1'b0;

        // A, B, C with C carrying last and keep 1100
        clear_obs();
        step(1, 0, 4'hF, 32'hA, 1);
        step(1, 0, 4'hF, 32'hB, 1);
        step(1, 1, 4'hC, 32'hC, 1);
        repeat (3) step(0, 0, 4'h0, 32'h0, 1);
        chk("abc_nbeats", 64'(obs_q.size()), 64'd3);
        chk("abc_beat_c", 64'(obs_q[2]), 64'({32'hC, 4'hC, 1'b1}));
        chk("abc_len", 64'(rep_q[0]), 64'({1'b0, 16'd10}));

        // 5-beat frame held back by 20 cycles of ready low
        clear_obs();
        for (int i = 0; i < 5; i++) step(1, i == 4, 4'hF, 32'(100 + i), 0);
        repeat (15) step(0, 0, 4'h0, 32'h0, 0);
        chk("stall_ovf", 64'(bus.overflow), 64'h0);
        chk("stall_len", 64'(rep_q[0]), 64'({1'b0, 16'd20}));
        repeat (8) step(0, 0, 4'h0, 32'h0, 1);
        chk("stall_nbeats", 64'(obs_q.size()), 64'd5);
        for (int i = 0; i < 5; i++) chk("stall_order", 64'(obs_q[i].data), 64'(100 + i));

        // back-to-back single-beat frames
        clear_obs();
        for (int i = 0; i < 8; i++) step(1, 1, 4'h8, 32'(200 + i), 1);
        repeat (2) step(0, 0, 4'h0, 32'h0, 1);
        chk("single_nrep", 64'(rep_q.size()), 64'd8);
        for (int i = 0; i < 8; i++) chk("single_len", 64'(rep_q[i]), 64'({1'b0, 16'd1}));
        for (int i = 0; i < 8; i++) chk("single_last", 64'(obs_q[i].last), 64'h1);

        // 20-beat frame into a stalled 16-deep buffer
        clear_obs();
        for (int i = 0; i < 20; i++) step(1, i == 19, (i == 19) ? 4'h8 : 4'hF, 32'(300 + i), 0);
        chk("ovf_sticky", 64'(bus.overflow), 64'h1);
        chk("fsm_term", 64'(dut.state_q), 64'(TERM));
        repeat (22) step(0, 0, 4'h0, 32'h0, 1);
        chk("ovf_nbeats", 64'(obs_q.size()), 64'd17);
        chk("ovf_beat16", 64'(obs_q[15].data), 64'd315);
        chk("ovf_term", 64'(obs_q[16]), 64'({32'h0, 4'h0, 1'b1}));
        chk("ovf_len", 64'(rep_q[0]), 64'({1'b1, 16'd64}));

        // reset in the middle of a frame
        clear_obs();
        step(1, 0, 4'hF, 32'h1, 0);
        step(1, 0, 4'hF, 32'h2, 0);
        bus.valid_in = 0;
        rst = 1'b1;
        #1;
        chk("rst_out", 64'({bus.valid_out, bus.last_out, bus.keep_out, bus.data_out}), 64'h0);
        chk("rst_len", 64'({bus.len_valid, bus.len_err, bus.len_bytes}), 64'h0);
        chk("rst_ovf", 64'(bus.overflow), 64'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(1, 1, 4'hE, 32'h55, 1);
        repeat (2) step(0, 0, 4'h0, 32'h0, 1);
        chk("post_rst_len", 64'(rep_q[0]), 64'({1'b0, 16'd3}));

        // random traffic in phases of varying load and backpressure
        pv = 50; pr = 50;
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) begin
                pv = 20 + 20 * int'($urandom_range(0, 4));
                pr = 5 + 25 * int'($urandom_range(0, 3));
            end
            step($urandom_range(0, 99) < pv, $urandom_range(0, 99) < 25,
                 keeps[$urandom_range(0, 3)], $urandom, $urandom_range(0, 99) < pr);
        end
        repeat (40) step(0, 0, 4'h0, 32'h0, 1);
        check_outputs();

        // narrow length counter saturates
        for (int i = 0; i < 5; i++) begin
            bus4.valid_in = 1; bus4.last_in = (i == 4); bus4.keep_in = 4'hF; bus4.data_in = 32'(i);
            @(posedge clk);
            @(negedge clk);
        end
        bus4.valid_in = 0; bus4.last_in = 0;
        seen = 0;
        for (int w = 0; w < 5 && !seen; w++) begin
            if (bus4.len_valid) begin
                seen = 1;
                chk("len4_bytes", 64'(bus4.len_bytes), 64'd15);
                chk("len4_err", 64'(bus4.len_err), 64'h0);
            end else begin
                @(posedge clk);
                @(negedge clk);
            end
        end
        chk("len4_seen", 64'(seen), 64'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_ingress_buffer.md
# stream_ingress_buffer

Receive-side buffer that consumes the unthrottled beat stream produced by the data master (valid/last/keep/data, no ready) and re-presents it downstream with a valid/ready handshake. It absorbs bursts in a FIFO and counts accepted bytes per frame. When the FIFO overflows it drops beats and still guarantees a terminated frame downstream. It sits directly after the stream source, in front of any backpressuring consumer.

## Interface
- DATA_WD, 32, data width in bits
- DATA_BYTE_WD, 4, keep width (DATA_WD/8)
- FIFO_DEPTH, 16, entries; power of two, ≥2
- LEN_WD, 16, frame byte-count width
- clk  input  1  clock; all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- valid_in  input  1  upstream beat valid; no backpressure possible
- last_in  input  1  final beat of frame
- keep_in  input  DATA_BYTE_WD  byte enables; MSB-aligned (1111/1110/1100/1000)
- data_in  input  DATA_WD  beat payload
- valid_out  output  1  downstream beat valid
- ready_out  input  1  downstream ready
- last_out  output  1  final beat of frame
- keep_out  output  DATA_BYTE_WD  byte enables; 0000 on a terminator beat
- data_out  output  DATA_WD  payload; 0 on a terminator beat
- len_valid  output  1  one-cycle pulse: frame length report
- len_bytes  output  LEN_WD  accepted bytes of reported frame
- len_err  output  1  reported frame lost ≥1 beat
- overflow  output  1  sticky: any beat dropped since reset

## Operation
- Beat accepted when valid_in=1, FIFO not full at cycle start, and the FSM is not discarding. Entry = {data, keep, last}.
- FSM states: PASS, DROP, TERM.
  - PASS: accept beats. A beat arriving while full is dropped, overflow set, frame err flag set. If it was not last, go to DROP. If it was last, go to TERM.
  - DROP: discard non-last beats. On last_in: if not full, write terminator {0, 0000, 1}, report, go to PASS; else go to TERM.
  - TERM: write terminator on the first cycle with space, report, go to PASS. A valid_in beat arriving that same cycle is dropped, sets overflow, and its frame starts with err set. The FSM goes to DROP, or back to TERM if that beat has last_in.
- Byte counter: add popcount(keep_in) per accepted beat; saturate at 2^LEN_WD−1. Clear after each report.
- Report: when the last beat or terminator is written, the next cycle has len_valid=1 and len_bytes/len_err for that frame. err is cleared with the counter.
- Downstream: beat leaves when valid_out && ready_out. Order is preserved. Frames are never split or merged.

## Timing
- Reset values: valid_out, last_out, len_valid, len_err, overflow = 0; keep_out, data_out, len_bytes = 0. FIFO empty, FSM = PASS, counter = 0.
- Write-to-output latency is 1 cycle: a beat written at edge N is on valid_out after edge N (FIFO first-word-fall-through).
- Full = level==FIFO_DEPTH, evaluated at cycle start. A same-cycle read does not free space for a same-cycle write.
- Simultaneous read and write when not full: the level is unchanged.
- Output fields hold stable while valid_out && !ready_out.
- Reset mid-frame discards FIFO contents, the partial count, and overflow. The first beat after reset starts a new frame.

## Structure
- Package stream_pkg:
  - beat_t struct {data, keep, last}
  - ingress_state_t enum {PASS, DROP, TERM}
  - TERM_BEAT constant
- Sub-module sync_fifo (parameterized width/depth, FWFT, level output) holds the beat storage. FSM, byte counter and report logic live in the top.

## Test plan
- Frame A,B,C with keep 1111,1111,1100, last on C, ready_out=1 -> same three beats out in order, last_out on C; len_bytes=10, len_err=0.
- ready_out=0 for 20 cycles during a 5-beat frame (depth 16) -> no drop, overflow=0. Beats released in order once ready_out=1; len_bytes=20 reported at input time.
- ready_out=0, 20-beat frame (last keep 1000) -> 16 beats stored, beats 17–20 dropped, FSM in TERM. After ready_out=1: terminator keep 0000/last 1 follows beat 16; len_bytes=64, len_err=1, overflow=1.
- Single-beat frames, keep 1000, back-to-back every cycle -> len_valid every cycle, len_bytes=1 each, all out with last_out=1.
- LEN_WD=4, 5 beats of keep 1111 -> len_bytes=15 (saturated), len_err=0.
- rst asserted after 2 beats of a frame -> all outputs 0 immediately, valid_out=0, overflow=0. The next 1-beat frame with keep 1110 reports len_bytes=3.
